// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: iomem-mapped input conditioner for the PicoSoC buttons.
// Each input goes through a 2-FF synchronizer and a debounce counter. Edges
// on the debounced level latch into sticky RISE/FALL event bits.
// Registers: 0x00 STATE (RO), 0x04 EVENT (W1C), 0x08 IRQ_MASK (RW).
// Optional feature macro: PICOSOC_BTN_IRQ_EN builds IRQ_MASK and the irq output.
// When the macro is undefined, irq is tied low and IRQ_MASK reads 0.

module btn_input_lane #(
    parameter int   DEBOUNCE_CYCLES = 12000,
    parameter logic IDLE            = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The new level is accepted on the edge where the mismatch has lasted long enough.
    assign accept = (s2 != stable) && (cnt == CNT_LAST);
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    // Synchronize the pad, then count consecutive mismatch cycles against the stable level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1     <= IDLE;
            s2     <= IDLE;
            stable <= IDLE;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable || accept) cnt <= '0;
            else                        cnt <= cnt + CW'(1);
            if (accept) stable <= s2;
        end
    end
endmodule

module btn_input_ctrl #(
    parameter int                NUM_IN          = 5,
    parameter int                DEBOUNCE_CYCLES = 12000,
    parameter logic [NUM_IN-1:0] IDLE_LEVEL      = {NUM_IN{1'b1}},
    parameter logic [7:0]        ADDR_PAGE       = 8'h08
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_IN-1:0] raw_in,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic              irq
);
    logic [NUM_IN-1:0] stable, set_rise, set_fall;
    logic [NUM_IN-1:0] evt_rise, evt_fall;
    logic [NUM_IN-1:0] mask_rise, mask_fall;
    logic [NUM_IN-1:0] clr_rise, clr_fall;
    logic [31:0]       bmask, wmask, rd_word;
    logic [7:0]        off;
    logic              acc, wr;
    logic              unused_ok;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_lane
            btn_input_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE           (IDLE_LEVEL[g])
            ) u_lane (
                .clk   (clk),
                .resetn(resetn),
                .raw   (raw_in[g]),
                .stable(stable[g]),
                .rise  (set_rise[g]),
                .fall  (set_fall[g])
            );
        end
    endgenerate

    assign off   = iomem_addr[7:0];
    assign acc   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
    assign wr    = acc && (iomem_wstrb != 4'h0);
    assign bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wmask = iomem_wdata & bmask;

    assign clr_rise = (wr && off == 8'h04) ? wmask[NUM_IN-1:0]    : '0;
    assign clr_fall = (wr && off == 8'h04) ? wmask[16 +: NUM_IN]  : '0;

    assign unused_ok = ^{iomem_addr[23:8], wmask};

    // Register readback mux; anything not decoded reads zero.
    always_comb begin
        rd_word = '0;
        case (off)
            8'h00: rd_word[NUM_IN-1:0] = stable;
            8'h04: begin
                rd_word[NUM_IN-1:0]   = evt_rise;
                rd_word[16 +: NUM_IN] = evt_fall;
            end
            8'h08: begin
                rd_word[NUM_IN-1:0]   = mask_rise;
                rd_word[16 +: NUM_IN] = mask_fall;
            end
            default: rd_word = '0;
        endcase
    end

    // Single-cycle response strobe; rdata captures pre-write register state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= acc ? rd_word : '0;
        end
    end

    // Sticky events: a new edge on the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            evt_rise <= '0;
            evt_fall <= '0;
        end else begin
            evt_rise <= (evt_rise & ~clr_rise) | set_rise;
            evt_fall <= (evt_fall & ~clr_fall) | set_fall;
        end
    end

`ifdef PICOSOC_BTN_IRQ_EN
    // Byte-merged mask write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask_rise <= '0;
            mask_fall <= '0;
        end else if (wr && off == 8'h08) begin
            mask_rise <= (mask_rise & ~bmask[NUM_IN-1:0])   | wmask[NUM_IN-1:0];
            mask_fall <= (mask_fall & ~bmask[16 +: NUM_IN]) | wmask[16 +: NUM_IN];
        end
    end

    // Registered level interrupt from any unmasked pending event.
    always_ff @(posedge clk) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= |((evt_rise & mask_rise) | (evt_fall & mask_fall));
    end
`else
    assign mask_rise = '0;
    assign mask_fall = '0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with a short debounce window.
module tb_btn_input_ctrl;
    localparam int D = 8;
`ifdef PICOSOC_BTN_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif
    localparam logic [31:0] A_STATE = 32'h0800_0000;
    localparam logic [31:0] A_EVENT = 32'h0800_0004;
    localparam logic [31:0] A_MASK  = 32'h0800_0008;

    logic        clk, resetn;
    logic [4:0]  raw;
    logic        valid, ready, irq;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] d;
    int checks = 0;
    int errors = 0;

    btn_input_ctrl #(.NUM_IN(5), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .resetn(resetn), .raw_in(raw),
        .iomem_valid(valid), .iomem_ready(ready), .iomem_wstrb(wstrb),
        .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] data);
        valid = 1'b1; addr = a; wstrb = 4'h0; wdata = '0;
        tick(1);
        chk("rd_rdy", {31'b0, ready}, 32'd1);
        data = rdata;
        valid = 1'b0;
        tick(1);
        chk("rd_rdy_drop", {31'b0, ready}, 32'd0);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        valid = 1'b1; addr = a; wstrb = s; wdata = v;
        tick(1);
        chk("wr_rdy", {31'b0, ready}, 32'd1);
        valid = 1'b0; wstrb = 4'h0;
        tick(1);
        chk("wr_rdy_drop", {31'b0, ready}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_rd(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; raw = 5'h1F; valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
        tick(3);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        resetn = 1'b1;
        tick(3 * D);
        rd_chk("state_idle", A_STATE, 32'h1F);
        rd_chk("evt_idle", A_EVENT, 32'h0);
        chk("irq_idle", {31'b0, irq}, 32'd0);

        // glitch one cycle shorter than the window
        raw[1] = 1'b0; tick(D - 1); raw[1] = 1'b1; tick(2 * D);
        rd_chk("glitch_state", A_STATE, 32'h1F);
        rd_chk("glitch_evt", A_EVENT, 32'h0);

        // event sets on edge D+2 after the change: read accepted at D+2 sees 0
        raw[1] = 1'b0; tick(D + 1);
        rd_chk("evt_early", A_EVENT, 32'h0);
        rd_chk("state_fall", A_STATE, 32'h1D);
        rd_chk("evt_fall", A_EVENT, 32'h0002_0000);
        raw[1] = 1'b1; tick(2 * D);
        rd_chk("evt_both", A_EVENT, 32'h0002_0002);
        bus_wr(A_EVENT, 32'h0002_0002, 4'hF);
        rd_chk("evt_clr", A_EVENT, 32'h0);

        // read accepted at D+3 already sees the event
        raw[1] = 1'b0; tick(D + 2);
        rd_chk("evt_exact", A_EVENT, 32'h0002_0000);
        tick(D);
        bus_wr(A_EVENT, 32'h0002_0000, 4'hF);
        rd_chk("evt_clr2", A_EVENT, 32'h0);

        // irq on rise of input 1
        bus_wr(A_MASK, 32'h0000_0002, 4'hF);
        rd_chk("mask_rd", A_MASK, IRQ_EN ? 32'h2 : 32'h0);
        raw[1] = 1'b1; tick(D + 2);
        chk("irq_pre", {31'b0, irq}, 32'd0);
        tick(1);
        chk("irq_set", {31'b0, irq}, {31'b0, IRQ_EN});
        bus_wr(A_EVENT, 32'h0000_0002, 4'hF);
        chk("irq_clr", {31'b0, irq}, 32'd0);
        rd_chk("evt_clr3", A_EVENT, 32'h0);

        // W1C on the same edge a new fall is accepted
        raw[1] = 1'b0; tick(D + 1);
        bus_wr(A_EVENT, 32'h0002_0000, 4'hF);
        rd_chk("set_wins", A_EVENT, 32'h0002_0000);
        raw[1] = 1'b1; tick(2 * D);
        rd_chk("evt_pair", A_EVENT, 32'h0002_0002);
        bus_wr(A_EVENT, 32'h0002_0002, 4'b0001);
        rd_chk("w1c_strb0", A_EVENT, 32'h0002_0000);
        bus_wr(A_EVENT, 32'h0002_0002, 4'b0100);
        rd_chk("w1c_strb2", A_EVENT, 32'h0);

        // ignored writes, unmapped offset, foreign page
        bus_wr(A_STATE, 32'h0, 4'hF);
        rd_chk("state_ro", A_STATE, 32'h1F);
        rd_chk("off10", 32'h0800_0010, 32'h0);
        valid = 1'b1; addr = 32'h0300_0000; wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("page_rdy", {31'b0, ready}, 32'd0);
        end
        valid = 1'b0;

        // all-ones mask with a fall on input 0
        bus_wr(A_MASK, 32'hFFFF_FFFF, 4'hF);
        rd_chk("mask_all", A_MASK, IRQ_EN ? 32'h001F_001F : 32'h0);
        raw[0] = 1'b0; tick(D + 3);
        rd_chk("evt_in0", A_EVENT, 32'h0001_0000);
        chk("irq_all", {31'b0, irq}, {31'b0, IRQ_EN});

        // reset during a transaction and mid-debounce
        raw[0] = 1'b1; valid = 1'b1; addr = A_EVENT; resetn = 1'b0;
        tick(1);
        chk("rst_mid_ready", {31'b0, ready}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_irq", {31'b0, irq}, 32'd0);
        valid = 1'b0;
        tick(1);
        chk("rst_mid_ready2", {31'b0, ready}, 32'd0);
        resetn = 1'b1;
        rd_chk("rst_evt", A_EVENT, 32'h0);
        rd_chk("rst_mask", A_MASK, 32'h0);
        tick(2 * D);
        rd_chk("rst_state", A_STATE, 32'h1F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
